// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue: write-back queue feeding the register file write port.
// Results from execution units are buffered in a small FIFO and drained
// one entry per cycle. Writes to register 0 are dropped at the input.
// Pending entries are snooped by the register file read addresses, so a
// read never returns a value that a queued write is about to replace.
//
// Build option: define REGFILE_WB_FWD_EN to build the forwarding compare and
// priority logic. When it is undefined, fwd_hit and fwd_data are tied to 0
// and no compare logic is generated.
module regfile_wb_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_DEPTH  = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int RD_DEPTH   = 2,
  parameter int Q_DEPTH    = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ADDR_WIDTH-1:0]          in_addr,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic                           wb_stall,
  output logic                           wr,
  output logic [ADDR_WIDTH-1:0]          rw,
  output logic [DATA_WIDTH-1:0]          d,
  input  logic [ADDR_WIDTH*RD_DEPTH-1:0] rr,
  output logic [RD_DEPTH-1:0]            fwd_hit,
  output logic [DATA_WIDTH*RD_DEPTH-1:0] fwd_data,
  output logic [ADDR_WIDTH:0]            count,
  output logic                           empty
);

  localparam int PW = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW:0]           occ;
  logic [ADDR_WIDTH-1:0] q_addr [Q_DEPTH];
  logic [DATA_WIDTH-1:0] q_data [Q_DEPTH];

  logic push;
  logic pop;
  logic full;

  // Handshake and drain qualifiers. in_ready only looks at registered
  // occupancy, so wb_stall has no combinational path to it.
  always_comb begin
    empty    = (occ == '0);
    full     = (occ == (PW+1)'(Q_DEPTH));
    in_ready = !full;
    push     = in_valid && in_ready && (in_addr != '0);
    pop      = !empty && !wb_stall;
  end

  // Pointer and occupancy state; reset discards anything still pending.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Entry storage is left uninitialised; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= in_addr;
      q_data[wr_ptr] <= in_data;
    end
  end

  // Register file write port driven from the head entry, zeroed when empty.
  always_comb begin
    wr = pop;
    rw = '0;
    d  = '0;
    if (!empty) begin
      rw = q_addr[rd_ptr];
      d  = q_data[rd_ptr];
    end
  end

  assign count = (ADDR_WIDTH+1)'(occ);

`ifdef REGFILE_WB_FWD_EN
  logic [PW-1:0]      age_idx [Q_DEPTH];
  logic [Q_DEPTH-1:0] age_vld;

  // Slots listed oldest to youngest, with a flag for each occupied one.
  always_comb begin
    for (int k = 0; k < Q_DEPTH; k++) begin
      age_idx[k] = rd_ptr + PW'(k);
      age_vld[k] = ((PW+1)'(k) < occ);
    end
  end

  // Per read port, scan oldest to youngest so the youngest match is kept.
  always_comb begin
    fwd_hit  = '0;
    fwd_data = '0;
    for (int p = 0; p < RD_DEPTH; p++) begin
      if (rr[ADDR_WIDTH*p +: ADDR_WIDTH] != '0) begin
        for (int k = 0; k < Q_DEPTH; k++) begin
          if (age_vld[k] && (q_addr[age_idx[k]] == rr[ADDR_WIDTH*p +: ADDR_WIDTH])) begin
            fwd_hit[p]                         = 1'b1;
            fwd_data[DATA_WIDTH*p +: DATA_WIDTH] = q_data[age_idx[k]];
          end
        end
      end
    end
  end
`else
  logic unused_rr;

  assign unused_rr = ^rr;
  assign fwd_hit   = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Testbench for regfile_wb_queue: directed scenarios plus a randomized run,
// checked against a queue-based reference model of the write-back queue.
module tb_regfile_wb_queue;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int RD = 2;
  localparam int QD = 4;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [AW-1:0]  in_addr;
  logic [DW-1:0]  in_data;
  logic           wb_stall;
  logic           wr;
  logic [AW-1:0]  rw;
  logic [DW-1:0]  d;
  logic [AW*RD-1:0] rr;
  logic [RD-1:0]  fwd_hit;
  logic [DW*RD-1:0] fwd_data;
  logic [AW:0]    count;
  logic           empty;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending entries {addr,data}, oldest at index 0.
  logic [AW+DW-1:0] mq [$];
  logic [DW-1:0]    rf_model [32];
  logic [DW-1:0]    rf_dut   [32];

  logic           s_wr;
  logic [AW-1:0]  s_rw;
  logic [DW-1:0]  s_d;

  regfile_wb_queue #(
    .DATA_WIDTH(DW), .REG_DEPTH(32), .ADDR_WIDTH(AW), .RD_DEPTH(RD), .Q_DEPTH(QD)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .wb_stall(wb_stall),
    .wr(wr), .rw(rw), .d(d), .rr(rr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .count(count), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Compare every output against what the model predicts for the current inputs.
  task automatic check_outputs();
    int sz;
    logic [AW-1:0] ra;
    logic          e_hit;
    logic [DW-1:0] e_dat;
    sz = mq.size();
    chk("empty", 64'(empty), 64'(sz == 0));
    chk("in_ready", 64'(in_ready), 64'(sz < QD));
    chk("count", 64'(count), 64'(sz));
    chk("wr", 64'(wr), 64'((sz != 0) && !wb_stall));
    chk("rw", 64'(rw), (sz != 0) ? 64'(mq[0][AW+DW-1:DW]) : 64'd0);
    chk("d", 64'(d), (sz != 0) ? 64'(mq[0][DW-1:0]) : 64'd0);
    for (int p = 0; p < RD; p++) begin
      ra    = rr[AW*p +: AW];
      e_hit = 1'b0;
      e_dat = '0;
`ifdef REGFILE_WB_FWD_EN
      if (ra != 0) begin
        for (int i = 0; i < sz; i++) begin
          if (mq[i][AW+DW-1:DW] == ra) begin
            e_hit = 1'b1;
            e_dat = mq[i][DW-1:0];
          end
        end
      end
`endif
      chk("fwd_hit", 64'(fwd_hit[p]), 64'(e_hit));
      chk("fwd_data", 64'(fwd_data[DW*p +: DW]), 64'(e_dat));
    end
    s_wr = wr;
    s_rw = rw;
    s_d  = d;
  endtask

  // One clock cycle: drive inputs at the falling edge, check, then advance the model.
  task automatic step(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] dt,
                      input logic st, input logic [AW*RD-1:0] rrv);
    int  sz;
    logic do_pop;
    logic do_push;
    @(negedge clk);
    in_valid = v;
    in_addr  = a;
    in_data  = dt;
    wb_stall = st;
    rr       = rrv;
    #1;
    check_outputs();
    sz      = mq.size();
    do_pop  = (sz != 0) && !st;
    do_push = v && (sz < QD) && (a != 0);
    @(posedge clk);
    if (s_wr) rf_dut[s_rw] = s_d;
    if (do_pop) begin
      rf_model[mq[0][AW+DW-1:DW]] = mq[0][DW-1:0];
      void'(mq.pop_front());
    end
    if (do_push) mq.push_back({a, dt});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    wb_stall = 1'b0;
    rr       = '0;
    for (int i = 0; i < 32; i++) begin
      rf_model[i] = '0;
      rf_dut[i]   = '0;
    end

    // Reset then idle.
    #1;
    chk("rst_wr", 64'(wr), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_fwd", 64'(fwd_hit), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    idle(10);

    // Single write to register 5.
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0);
    @(negedge clk);
    #1;
    chk("single_wr", 64'(wr), 64'd1);
    chk("single_rw", 64'(rw), 64'd5);
    chk("single_d", 64'(d), 64'hDEADBEEF);
    step(1'b0, '0, '0, 1'b0, '0);
    idle(1);
    chk("single_empty", 64'(empty), 64'd1);
    chk("single_rf5", 64'(rf_dut[5]), 64'hDEADBEEF);

    // Register 0 is acknowledged but never queued.
    step(1'b1, 5'd0, 32'h1234, 1'b0, '0);
    idle(3);
    chk("r0_count", 64'(count), 64'd0);

    // Fill under stall, reject a fifth push, then drain in order.
    for (int i = 1; i <= 4; i++) step(1'b1, AW'(i), DW'(i * 32'h11), 1'b1, '0);
    step(1'b1, 5'd9, 32'h99, 1'b1, '0);
    chk("full_count", 64'(count), 64'd4);
    chk("full_ready", 64'(in_ready), 64'd0);
    idle(5);
    chk("drain_empty", 64'(empty), 64'd1);
    for (int i = 1; i <= 4; i++) chk("drain_rf", 64'(rf_dut[i]), 64'(i * 32'h11));
    chk("drain_rf9", 64'(rf_dut[9]), 64'd0);

    // Youngest of two pending writes to r7 is forwarded; r3 misses.
    step(1'b1, 5'd7, 32'hA, 1'b1, '0);
    step(1'b1, 5'd7, 32'hB, 1'b1, '0);
    step(1'b0, '0, '0, 1'b1, {5'd3, 5'd7});
    @(negedge clk);
    #1;
`ifdef REGFILE_WB_FWD_EN
    chk("fwd_hit_dir", 64'(fwd_hit), 64'b01);
    chk("fwd_p0_dir", 64'(fwd_data[DW-1:0]), 64'hB);
`else
    chk("fwd_hit_dir", 64'(fwd_hit), 64'b00);
    chk("fwd_p0_dir", 64'(fwd_data[DW-1:0]), 64'h0);
`endif
    chk("fwd_p1_dir", 64'(fwd_data[2*DW-1:DW]), 64'h0);
    idle(3);
    chk("same_addr_rf7", 64'(rf_dut[7]), 64'hB);

    // Asynchronous reset while three entries are draining.
    for (int i = 0; i < 3; i++) step(1'b1, AW'(20 + i), DW'(32'hC0 + i), 1'b1, '0);
    @(negedge clk);
    wb_stall = 1'b0;
    in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_wr", 64'(wr), 64'd0);
    chk("arst_empty", 64'(empty), 64'd1);
    chk("arst_count", 64'(count), 64'd0);
    mq.delete();
    @(negedge clk);
    rst = 1'b1;
    idle(4);
    for (int i = 0; i < 3; i++) chk("arst_stale", 64'(rf_dut[20 + i]), 64'd0);

    // Randomized traffic with a narrow address range to force collisions.
    for (int n = 0; n < 600; n++) begin
      step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 9) < 3), {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))});
    end
    idle(6);
    for (int i = 1; i < 32; i++) chk("rf_final", 64'(rf_dut[i]), 64'(rf_model[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
